// File: rtl/sr_pkg.sv
// rtl/sr_pkg.sv - op encodings, FSM states and counter sizing helper for the SR latch driver
package sr_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_RST  = 2'b10;
  localparam logic [1:0] OP_TOG  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    SETTLE,
    CHECK
  } sr_state_e;

  // Bits needed to hold values 0..value-1; never narrower than one bit.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/sr_cycle_counter.sv
// rtl/sr_cycle_counter.sv - loadable down-counter with terminal-count flag for pulse/settle timing
module sr_cycle_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // Parks at zero so tc stays asserted until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// rtl/sr_latch_driver.sv - sequences en/S/R pulses into a gated SR NOR latch and verifies Q/Q' readback
module sr_latch_driver
  import sr_pkg::*;
#(
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 1,
  parameter int MAX_RETRY  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       q_fb,
  input  logic       qn_fb,
  output logic       en,
  output logic       s,
  output logic       r,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       rd_q
);

  localparam int CNT_MAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
  localparam int CW      = clog2(CNT_MAX + 1);
  localparam int RW      = clog2(MAX_RETRY + 1);

  localparam logic [CW-1:0] PULSE_LOAD  = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = (SETTLE_CYC > 0) ? CW'(SETTLE_CYC - 1) : '0;
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  sr_state_e     state, state_d;
  logic          target, target_d;
  logic          is_hold, is_hold_d;
  logic [RW-1:0] retry_cnt, retry_cnt_d;
  logic          cnt_load;
  logic [CW-1:0] cnt_load_value;
  logic          cnt_tc;
  logic          evaluate;
  logic          readback_ok;
  logic          done_d, err_d;

  sr_cycle_counter #(.WIDTH(CW)) u_cycle_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .tc         (cnt_tc)
  );

  always_comb begin
    state_d        = state;
    target_d       = target;
    is_hold_d      = is_hold;
    retry_cnt_d    = retry_cnt;
    cnt_load       = 1'b0;
    cnt_load_value = PULSE_LOAD;
    evaluate       = 1'b0;
    done_d         = 1'b0;
    err_d          = 1'b0;
    // Equal Q and Q' (forbidden or undriven latch) fails both checks.
    readback_ok    = is_hold ? (q_fb != qn_fb) : ((q_fb == target) && (qn_fb == ~target));

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          retry_cnt_d = '0;
          is_hold_d   = (cmd_op == OP_HOLD);
          case (cmd_op)
            OP_SET:  target_d = 1'b1;
            OP_RST:  target_d = 1'b0;
            OP_TOG:  target_d = ~q_fb;
            default: target_d = target;
          endcase
          if (cmd_op == OP_HOLD) begin
            state_d = CHECK;
          end else begin
            state_d  = PULSE;
            cnt_load = 1'b1;
          end
        end
      end
      PULSE: begin
        if (cnt_tc) begin
          if (SETTLE_CYC > 0) begin
            state_d        = SETTLE;
            cnt_load       = 1'b1;
            cnt_load_value = SETTLE_LOAD;
          end else begin
            evaluate = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (cnt_tc) evaluate = 1'b1;
      end
      CHECK: begin
        // Holds sample here; for pulsed commands this is the quiet gap before a retry.
        if (is_hold) begin
          evaluate = 1'b1;
        end else begin
          state_d  = PULSE;
          cnt_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (evaluate) begin
      if (readback_ok) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end else if (retry_cnt < RETRY_LIMIT) begin
        retry_cnt_d = retry_cnt + RW'(1);
        state_d     = CHECK;
      end else begin
        done_d  = 1'b1;
        err_d   = 1'b1;
        state_d = IDLE;
      end
    end
  end

  // Outputs decode the next state so every pin comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      target    <= 1'b0;
      is_hold   <= 1'b0;
      retry_cnt <= '0;
      cmd_ready <= 1'b0;
      en        <= 1'b0;
      s         <= 1'b0;
      r         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      state     <= state_d;
      target    <= target_d;
      is_hold   <= is_hold_d;
      retry_cnt <= retry_cnt_d;
      cmd_ready <= (state_d == IDLE);
      en        <= (state_d == PULSE);
      s         <= (state_d == PULSE) && target_d;
      r         <= (state_d == PULSE) && !target_d;
      busy      <= (state_d != IDLE);
      done      <= done_d;
      err       <= err_d;
      rd_q      <= done_d && q_fb;
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// tb/tb_sr_latch_driver.sv - scoreboard bench driving two sr_latch_driver configurations into SR latch models
module tb_sr_latch_driver;
  import sr_pkg::*;

  localparam int PC [2] = '{2, 1};
  localparam int SC [2] = '{1, 0};
  localparam int MR     = 1;

  typedef struct {
    int   cyc;
    logic err;
    logic rdq;
    int   enc;
    int   sc;
    int   rc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst       [2];
  logic       cmd_valid [2];
  logic [1:0] cmd_op    [2];
  logic       cmd_ready [2];
  logic       q_fb      [2];
  logic       qn_fb     [2];
  logic       en        [2];
  logic       s         [2];
  logic       r         [2];
  logic       busy      [2];
  logic       done      [2];
  logic       err       [2];
  logic       rd_q      [2];
  logic       force_bad [2];
  logic       model_q   [2];
  exp_t       sbq       [2][$];

  int cyc    = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  sr_latch_driver #(.PULSE_CYC(2), .SETTLE_CYC(1), .MAX_RETRY(MR)) dut0 (
    .clk(clk), .rst(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op[0]), .q_fb(q_fb[0]), .qn_fb(qn_fb[0]), .en(en[0]), .s(s[0]), .r(r[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0]), .rd_q(rd_q[0])
  );

  sr_latch_driver #(.PULSE_CYC(1), .SETTLE_CYC(0), .MAX_RETRY(MR)) dut1 (
    .clk(clk), .rst(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op[1]), .q_fb(q_fb[1]), .qn_fb(qn_fb[1]), .en(en[1]), .s(s[1]), .r(r[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1]), .rd_q(rd_q[1])
  );

  task automatic check(input string name, input int d, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d, required %0d", name, d, act, req);
    end
  endtask

  for (genvar d = 0; d < 2; d++) begin : g_side
    logic q_lat   = 1'b0;
    int   en_acc  = 0;
    int   s_acc   = 0;
    int   r_acc   = 0;
    int   overlap = 0;
    int   en_base = 0;
    int   s_base  = 0;
    int   r_base  = 0;
    exp_t e;

    // Gated SR NOR latch: transparent while en, S=R=1 leaves Q unchanged here but is counted as overlap.
    always @(negedge clk) begin
      if (en[d] === 1'b1) begin
        if (s[d] && !r[d]) q_lat <= 1'b1;
        else if (r[d] && !s[d]) q_lat <= 1'b0;
      end
    end

    assign q_fb[d]  = force_bad[d] ? 1'b0 : q_lat;
    assign qn_fb[d] = force_bad[d] ? 1'b0 : ~q_lat;

    always @(posedge clk) begin
      if (rst[d] === 1'b0) begin
        en_acc <= en_acc + int'(en[d]);
        s_acc  <= s_acc + int'(s[d]);
        r_acc  <= r_acc + int'(r[d]);
        if (s[d] && r[d]) overlap <= overlap + 1;
      end
    end

    always @(negedge clk) begin
      if (rst[d] === 1'b0 && done[d] === 1'b1) begin
        if (sbq[d].size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done dut%0d: got done at cycle %0d, required none", d, cyc);
        end else begin
          e = sbq[d].pop_front();
          check("done_cycle", d, cyc, e.cyc);
          check("err", d, int'(err[d]), int'(e.err));
          check("rd_q", d, int'(rd_q[d]), int'(e.rdq));
          check("en_cycles", d, en_acc - en_base, e.enc);
          check("s_cycles", d, s_acc - s_base, e.sc);
          check("r_cycles", d, r_acc - r_base, e.rc);
        end
        en_base = en_acc;
        s_base  = s_acc;
        r_base  = r_acc;
      end
    end
  end

  task automatic issue(input int d, input logic [1:0] op, input bit keep);
    exp_t x;
    logic tgt;
    int   att;
    int   guard;
    guard = 0;
    while (cmd_ready[d] !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_timeout dut%0d: got cmd_ready=%b, required 1", d, cmd_ready[d]);
      return;
    end
    case (op)
      OP_SET:  tgt = 1'b1;
      OP_RST:  tgt = 1'b0;
      OP_TOG:  tgt = ~model_q[d];
      default: tgt = model_q[d];
    endcase
    att = force_bad[d] ? MR + 1 : 1;
    if (op == OP_HOLD) begin
      x.cyc = cyc + 2;
      x.enc = 0;
      x.sc  = 0;
      x.rc  = 0;
    end else begin
      x.cyc = cyc + 1 + PC[d] + SC[d] + (att - 1) * (PC[d] + SC[d] + 1);
      x.enc = att * PC[d];
      x.sc  = tgt ? x.enc : 0;
      x.rc  = tgt ? 0 : x.enc;
      model_q[d] = tgt;
    end
    x.err = force_bad[d];
    x.rdq = force_bad[d] ? 1'b0 : tgt;
    cmd_op[d]    = op;
    cmd_valid[d] = 1'b1;
    sbq[d].push_back(x);
    @(negedge clk);
    if (keep) begin
      guard = 0;
      while (cmd_ready[d] !== 1'b1 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
    end
    cmd_valid[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int guard;
    guard = 0;
    while ((sbq[d].size() != 0 || cmd_ready[d] !== 1'b1) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      n_cmp++;
      n_fail++;
      $display("FAIL idle_timeout dut%0d: got %0d pending, required 0", d, sbq[d].size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] op;
    for (int d = 0; d < 2; d++) begin
      rst[d]       = 1'b1;
      cmd_valid[d] = 1'b0;
      cmd_op[d]    = OP_HOLD;
      force_bad[d] = 1'b0;
      model_q[d]   = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_outputs", d,
            int'({en[d], s[d], r[d], busy[d], done[d], err[d], rd_q[d], cmd_ready[d]}), 0);
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) check("ready_after_reset", d, int'(cmd_ready[d]), 1);

    // Default configuration: set, toggle+reset back-to-back, set+hold, failing readback.
    issue(0, OP_SET, 1'b0);
    wait_idle(0);
    issue(0, OP_TOG, 1'b0);
    issue(0, OP_RST, 1'b0);
    wait_idle(0);
    issue(0, OP_SET, 1'b0);
    issue(0, OP_HOLD, 1'b0);
    wait_idle(0);
    force_bad[0] = 1'b1;
    issue(0, OP_SET, 1'b0);
    wait_idle(0);
    force_bad[0] = 1'b0;

    // Reset lands at E1 of a set.
    cmd_op[0]    = OP_SET;
    cmd_valid[0] = 1'b1;
    @(negedge clk);
    check("abort_en_before_rst", 0, int'(en[0]), 1);
    cmd_valid[0] = 1'b0;
    rst[0]       = 1'b1;
    @(negedge clk);
    check("abort_outputs", 0, int'({en[0], s[0], r[0], busy[0], done[0], cmd_ready[0]}), 0);
    rst[0] = 1'b0;
    @(negedge clk);
    check("abort_ready", 0, int'(cmd_ready[0]), 1);
    model_q[0] = 1'b1;
    issue(0, OP_RST, 1'b0);
    issue(0, OP_TOG, 1'b0);
    wait_idle(0);

    // Short configuration with cmd_valid held through busy.
    issue(1, OP_SET, 1'b1);
    issue(1, OP_TOG, 1'b1);
    force_bad[1] = 1'b1;
    issue(1, OP_SET, 1'b1);
    wait_idle(1);
    force_bad[1] = 1'b0;

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 25; i++) begin
        op = 2'($urandom_range(0, 3));
        if (op != OP_HOLD && $urandom_range(0, 5) == 0) begin
          wait_idle(d);
          force_bad[d] = 1'b1;
          issue(d, op, d == 1);
          wait_idle(d);
          force_bad[d] = 1'b0;
        end else begin
          issue(d, op, (d == 1) || ($urandom_range(0, 3) == 0));
        end
        repeat ($urandom_range(0, 1)) @(negedge clk);
      end
      wait_idle(d);
    end

    repeat (4) @(negedge clk);
    check("s_r_overlap", 0, g_side[0].overlap, 0);
    check("s_r_overlap", 1, g_side[1].overlap, 0);
    check("pending_left", 0, sbq[0].size(), 0);
    check("pending_left", 1, sbq[1].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
